dummy_rle_expander: RTL
=======================

# dummy_rle_expander

Run-length expander that reverses the leading-zero encoding done by the `lzc`-based dummy datapath. It accepts (count, empty) tokens over a valid/ready handshake and turns each one back into a serial bit stream: `count` zeros, then a terminating one. An all-zero token becomes WIDTH zeros. It sits inside the dummy IP integration exercise, downstream of the encoder side, and exercises `cf_math_pkg` and the common-cells dependency chain with real sequential logic.

## Interface
- `WIDTH`, default 16: width of the original word the tokens were encoded from; must be ≥ 2.
- `CNT_WIDTH`, default `cf_math_pkg::idx_width(WIDTH)`: token count width; derived, not to be overridden.
- `clk_i`  in  1  clock. Single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous abort; drops the token in flight.
- `in_cnt_i`  in  CNT_WIDTH  leading-zero count of the token.
- `in_empty_i`  in  1  token represents an all-zero word; `in_cnt_i` is ignored.
- `in_valid_i`  in  1  token valid.
- `in_ready_o`  out  1  token accepted when `in_valid_i && in_ready_o`.
- `out_bit_o`  out  1  serial data bit.
- `out_valid_o`  out  1  `out_bit_o` valid.
- `out_ready_i`  in  1  downstream accepts the bit.
- `tok_done_o`  out  1  one-cycle pulse in the cycle the last bit of a token is handshaked.
- `busy_o`  out  1  a token is being expanded (state ≠ IDLE).

## Operation
- FSM states: IDLE, ZEROS, ONE.
- Register `rem` is CNT_WIDTH+1 bits wide so that it can hold WIDTH. It counts the zeros still to emit.
- Token acceptance, per token type:
  - `empty=1`: `rem := WIDTH`, next state ZEROS, no terminating one.
  - `empty=0, cnt>0`: `rem := cnt`, next state ZEROS.
  - `empty=0, cnt=0`: next state ONE.
  - `empty=0, cnt ≥ WIDTH` is illegal: saturate to `WIDTH-1` and raise a simulation `$error`.
- ZEROS:
  - `out_bit_o=0`, `out_valid_o=1`.
  - On each out handshake, `rem` decrements.
  - When the handshake happens at `rem=1`: go to ONE for a non-empty token, otherwise the token is finished.
- ONE: `out_bit_o=1`, `out_valid_o=1`. The handshake finishes the token.
- Finishing a token:
  - Pulses `tok_done_o`.
  - If a new token handshakes in that same cycle, the FSM loads it directly. Otherwise it returns to IDLE.
- `in_ready_o` = `!clear_i && (state==IDLE || last_bit_handshake)`. The combinational path from `out_ready_i` to `in_ready_o` is intentional and gives zero-bubble back-to-back tokens.
- `clear_i`:
  - Next state IDLE, `rem := 0`.
  - No token is accepted that cycle and `tok_done_o` is suppressed.
  - `clear_i` wins over every simultaneous event.
- Output stability: while `out_valid_o && !out_ready_i`, `out_bit_o` and the state hold unchanged.
- IDLE: `out_valid_o=0`, `out_bit_o=0`.

## Timing
- Reset values: state IDLE, `rem=0`, `out_valid_o=0`, `out_bit_o=0`, `tok_done_o=0`, `busy_o=0`. `in_ready_o=1` once `rst_ni` is high, unless `clear_i` is asserted.
- Latency: a token accepted in cycle N presents its first bit in cycle N+1 (registered state).
- Throughput: one bit per cycle while `out_ready_i=1`. A token costs `cnt+1` cycles (non-empty) or WIDTH cycles (empty), with no idle cycle between consecutive tokens.
- Reset asserted mid-token: the outputs go to their reset values immediately, without waiting for a clock edge, and the partial token is lost.
- Out-stall on the last bit: the next token is not accepted until the last-bit handshake occurs.

## Test plan
- Reset, then token cnt=3, empty=0, `out_ready_i=1` -> bits 0,0,0,1 in cycles N+1..N+4; `tok_done_o` pulses in N+4; `busy_o` low in N+5.
- Back-to-back tokens cnt=0 then cnt=2, valid held high -> stream 1,0,0,1 with no gap; two `tok_done_o` pulses; `in_ready_o` high on both last-bit cycles.
- empty=1 token with WIDTH=16 and `in_cnt_i=5` -> exactly 16 zeros, no one, single `tok_done_o`.
- cnt=4 token with `out_ready_i` toggling 1,0,0,1,… -> `out_bit_o`/`out_valid_o` stable during stalls; bits 0,0,0,0,1 delivered in order; `tok_done_o` only on the final handshake.
- `clear_i` after 2 of the zeros of a cnt=6 token, with `in_valid_i` high in the same cycle -> next cycle IDLE, `out_valid_o=0`, no token accepted, no `tok_done_o`; the following token expands normally.
- Async reset asserted mid-ZEROS between clock edges -> `out_valid_o`/`busy_o` drop immediately; after release, a cnt=1 token yields 0,1.

Source files
------------

// File: rtl/dummy_rle_expander.sv
// ============================================================================
// dummy_rle_expander
// ----------------------------------------------------------------------------
// Run-length expander. This block undoes the leading-zero encoding produced on
// the encoder side of the dummy datapath. Each (count, empty) token that
// arrives on the input handshake becomes a serial bit stream:
//   - a non-empty token with count C gives C zeros followed by a single one;
//   - an empty token (all-zero original word) gives WIDTH zeros and no one.
//
// Handshake semantics, on both the token side and the bit side:
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. A producer that raises valid keeps valid and its payload stable
//   until that transfer. A consumer may raise or lower ready at any time.
//   On the input side, in_ready_o depends combinationally on out_ready_i.
//   This lets a new token be taken in the same cycle as the last bit of the
//   previous one, so consecutive tokens stream without a bubble.
//
// Parameters
//   WIDTH      width of the original word the tokens were encoded from (>= 2)
//   CNT_WIDTH  token count width. It is derived from WIDTH in the same way as
//              cf_math_pkg::idx_width(WIDTH); do not override it.
//
// Ports
//   clk_i        in   clock (single domain)
//   rst_ni       in   asynchronous active-low reset
//   clear_i      in   synchronous abort; drops the token in flight
//   in_cnt_i     in   leading-zero count of the token
//   in_empty_i   in   token encodes an all-zero word (in_cnt_i ignored)
//   in_valid_i   in   token valid
//   in_ready_o   out  token accepted when in_valid_i && in_ready_o
//   out_bit_o    out  serial data bit
//   out_valid_o  out  out_bit_o valid
//   out_ready_i  in   downstream accepts the bit
//   tok_done_o   out  pulses in the cycle the last bit of a token transfers
//   busy_o       out  a token is being expanded (state != IDLE)
// ============================================================================
module dummy_rle_expander #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [CNT_WIDTH-1:0] in_cnt_i,
    input  logic                 in_empty_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_bit_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 tok_done_o,
    output logic                 busy_o
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    // The remaining-zeros counter has one extra bit so that it can hold WIDTH
    // itself. An empty token loads the full word width.
    localparam int unsigned      REM_W     = CNT_WIDTH + 1;
    localparam logic [REM_W-1:0] REM_WIDTH = REM_W'(WIDTH);
    localparam logic [REM_W-1:0] REM_MAX   = REM_W'(WIDTH - 1);
    localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ZEROS = 2'd1,
        ST_ONE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q,   rem_d;    // zeros still to emit in ST_ZEROS
    logic             empty_q, empty_d;  // current token has no terminating one

    // ------------------------------------------------------------------------
    // Internal handshake / decode signals
    // ------------------------------------------------------------------------
    logic             out_hs;       // a bit transfers this cycle
    logic             last_bit;     // the transferring bit ends the token
    logic             in_hs;        // a token is accepted this cycle
    logic [REM_W-1:0] cnt_ext;      // in_cnt_i widened to counter width
    logic             cnt_illegal;  // non-empty count out of range
    logic [REM_W-1:0] cnt_load;     // count after saturation

    // ------------------------------------------------------------------------
    // Token count decode
    // ------------------------------------------------------------------------
    // A count of WIDTH or more cannot come from a real WIDTH-bit word. It is
    // clamped to WIDTH-1 so that the stream length stays bounded. With a
    // power-of-two WIDTH the count port is too narrow to carry such a value.
    always_comb begin
        cnt_ext     = {1'b0, in_cnt_i};
        cnt_illegal = (cnt_ext >= REM_WIDTH);
        cnt_load    = cnt_illegal ? REM_MAX : cnt_ext;
    end

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            empty_q <= empty_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 3: outputs and handshake decode
    // ------------------------------------------------------------------------
    // All outputs are decoded from the registered state. An asynchronous
    // reset therefore forces them to their idle values at once, without
    // waiting for a clock edge.
    always_comb begin
        out_valid_o = 1'b0;
        out_bit_o   = 1'b0;
        busy_o      = 1'b0;
        out_hs      = 1'b0;
        last_bit    = 1'b0;
        in_ready_o  = 1'b0;
        in_hs       = 1'b0;
        tok_done_o  = 1'b0;

        unique case (state_q)
            ST_ZEROS: begin
                out_valid_o = 1'b1;
                out_bit_o   = 1'b0;
                busy_o      = 1'b1;
            end
            ST_ONE: begin
                out_valid_o = 1'b1;
                out_bit_o   = 1'b1;
                busy_o      = 1'b1;
            end
            default: begin
                out_valid_o = 1'b0;
                out_bit_o   = 1'b0;
                busy_o      = 1'b0;
            end
        endcase

        out_hs = out_valid_o && out_ready_i;

        // An empty token ends on its last zero. A non-empty token ends on
        // its terminating one.
        last_bit = out_hs &&
                   ((state_q == ST_ONE) ||
                    ((state_q == ST_ZEROS) && (rem_q == REM_ONE) && empty_q));

        // The comb path out_ready_i -> in_ready_o lets a new token load
        // while the last bit of the previous token is transferring.
        in_ready_o = !clear_i && ((state_q == ST_IDLE) || last_bit);
        in_hs      = in_valid_i && in_ready_o;

        // An abort in the same cycle means the token did not complete.
        tok_done_o = last_bit && !clear_i;
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        empty_d = empty_q;

        if (clear_i) begin
            // Abort has priority over every other event in the cycle.
            state_d = ST_IDLE;
            rem_d   = '0;
            empty_d = 1'b0;
        end else if (in_hs) begin
            // Covers loading from IDLE and loading directly over a finishing
            // token. in_hs can only be true in those two situations.
            if (in_empty_i) begin
                state_d = ST_ZEROS;
                rem_d   = REM_WIDTH;
                empty_d = 1'b1;
            end else if (cnt_load == '0) begin
                state_d = ST_ONE;
                rem_d   = '0;
                empty_d = 1'b0;
            end else begin
                state_d = ST_ZEROS;
                rem_d   = cnt_load;
                empty_d = 1'b0;
            end
        end else if (out_hs) begin
            unique case (state_q)
                ST_ZEROS: begin
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = empty_q ? ST_IDLE : ST_ONE;
                        if (empty_q) begin
                            empty_d = 1'b0;
                        end
                    end
                end
                ST_ONE: begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // With no transfer, state and counter hold. This keeps out_bit_o
        // stable while the consumer stalls.
    end

    // ------------------------------------------------------------------------
    // Simulation-only check on out-of-range counts. The hardware saturates
    // these counts.
    // ------------------------------------------------------------------------
    always @(posedge clk_i) begin
        if (rst_ni && in_hs && !in_empty_i) begin
            assert (!cnt_illegal)
            else $error("dummy_rle_expander: token count %0d >= WIDTH %0d, saturated",
                        in_cnt_i, WIDTH);
        end
    end

endmodule
